// File: rtl/axi_lite_master_rw.sv
// ---------------------------------------------------------------------------
// axi_lite_master_rw
// Turns simple core requests into single AXI4-Lite read or write transactions,
// with one transaction in flight at a time.
//
// Ports
//   clk, rst              : clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready   : core request handshake; req_we selects write (1) or read (0)
//   req_addr/req_wdata/req_wstrb : request address, write data and byte strobes
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : data of the most recently completed read
//   resp_err              : last completion returned a non-OKAY response
//   ar*/r*                : AXI4-Lite read address and read data channels
//   aw*/w*/b*             : AXI4-Lite write address, write data and write response channels
// Every valid/ready output comes straight from a register, so there is no
// combinational path from any AXI input to any AXI output.
// ---------------------------------------------------------------------------
module axi_lite_master_rw #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                state_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [DATA_W/8-1:0]   wstrb_r;
    logic                  req_ready_r;
    logic                  arvalid_r;
    logic                  rready_r;
    logic                  awvalid_r;
    logic                  wvalid_r;
    logic                  bready_r;
    logic                  aw_done_r;
    logic                  w_done_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic [DATA_W-1:0]     resp_rdata_r;

    // Handshakes happening this cycle; the "ok" terms also count a channel
    // that already completed earlier in the write.
    logic aw_hs_s;
    logic w_hs_s;
    logic aw_ok_s;
    logic w_ok_s;

    assign aw_hs_s = awvalid_r & awready;
    assign w_hs_s  = wvalid_r & wready;
    assign aw_ok_s = aw_done_r | aw_hs_s;
    assign w_ok_s  = w_done_r | w_hs_s;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign araddr     = addr_r;
    assign arvalid    = arvalid_r;
    assign rready     = rready_r;
    assign awaddr     = addr_r;
    assign awvalid    = awvalid_r;
    assign wdata      = wdata_r;
    assign wstrb      = wstrb_r;
    assign wvalid     = wvalid_r;
    assign bready     = bready_r;

    // Transaction FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            wdata_r      <= '0;
            wstrb_r      <= '0;
            req_ready_r  <= 1'b0;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // req_ready is held low for the first idle cycle after reset
                    // and then raised; it drops again the moment a request is taken.
                    if (req_valid && req_ready_r) begin
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wstrb_r     <= req_wstrb;
                        req_ready_r <= 1'b0;
                        if (req_we) begin
                            state_r   <= WR_REQ;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                        end else begin
                            state_r   <= RD_ADDR;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready_r     <= 1'b0;
                        resp_rdata_r <= rdata;
                        resp_err_r   <= (rresp != 2'b00);
                        resp_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    // Leave as soon as both channels are accounted for, even when
                    // the last handshake lands in this very cycle.
                    if (aw_ok_s && w_ok_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready_r     <= 1'b0;
                        resp_err_r   <= (bresp != 2'b00);
                        resp_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b0;
                    arvalid_r    <= 1'b0;
                    rready_r     <= 1'b0;
                    awvalid_r    <= 1'b0;
                    wvalid_r     <= 1'b0;
                    bready_r     <= 1'b0;
                    aw_done_r    <= 1'b0;
                    w_done_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
